// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between the bus fabric and one SRAM responder.
// The master modport also carries HREADY, which the fabric's response mux drives.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM responder with programmable wait states,
// byte/halfword/word lanes, two-cycle ERROR response and write-to-read forwarding.
//
// Handshake: a transfer is accepted at a rising edge when HSEL, HREADY and
// HTRANS[1] are all high. Its data phase completes at the first later edge
// where HREADYOUT is high; HRDATA and HRESP are valid in that cycle.
module ahb_sram_slave #(
  parameter int MEM_AW      = 10,
  parameter int APERTURE_AW = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_sram_slave_if.slave  bus,
  output logic [2:0]       state_o
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  localparam logic [31:0] APER_MASK =
    32'((64'(1) << APERTURE_AW) - 64'(1)) & ~32'((64'(1) << (MEM_AW + 2)) - 64'(1));
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] idx_q;
  logic [1:0]        lo_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [1 << MEM_AW];

  logic              can_acc, take, illegal, wr_en, rd_load;
  logic [MEM_AW-1:0] acc_idx, rd_idx;
  logic [3:0]        wmask;
  logic [31:0]       rd_word;

  function automatic logic [3:0] lane_mask(input logic [1:0] lo, input logic [2:0] sz);
    case (sz)
      3'd0:    lane_mask = 4'b0001 << lo;
      3'd1:    lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Only states that present HREADYOUT=1 may take a new address phase.
  assign can_acc = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign take    = can_acc && bus.HSEL && bus.HREADY &&
                   ((bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11));
  assign illegal = (bus.HSIZE > 3'd2) ||
                   ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                   ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00)) ||
                   ((bus.HADDR & APER_MASK) != 32'd0);
  assign acc_idx = bus.HADDR[MEM_AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!take) begin
          state_d = ST_IDLE;
        end else if (illegal) begin
          state_d = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = WS_LOAD;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en   = (state_q == ST_DATA) && write_q;
  assign wmask   = lane_mask(lo_q, size_q);
  assign rd_idx  = take ? acc_idx : idx_q;
  assign rd_load = (state_d == ST_DATA) && (take ? !bus.HWRITE : !write_q);

  // A read launched on the edge where a write commits sees the merged word.
  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < 4; i++) begin
      if (wr_en && (idx_q == rd_idx) && wmask[i]) rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lo_q    <= 2'b00;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        idx_q   <= acc_idx;
        lo_q    <= bus.HADDR[1:0];
        size_q  <= bus.HSIZE;
        write_q <= bus.HWRITE;
      end
      if (rd_load) rdata_q <= rd_word;
    end
  end

  // Memory contents survive reset; only the pending write is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign bus.HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
  assign bus.HRDATA    = rdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with zero wait states and one
// with three, sharing address/control lines but selected individually.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_sel0, m_sel1, m_write;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_trans;
  logic [2:0]  m_size;
  logic [2:0]  st0, st1;
  int          checks = 0;
  int          failures = 0;

  ahb_sram_slave_if b0 ();
  ahb_sram_slave_if b1 ();

  assign b0.HSEL   = m_sel0;
  assign b1.HSEL   = m_sel1;
  assign b0.HADDR  = m_addr;   assign b1.HADDR  = m_addr;
  assign b0.HTRANS = m_trans;  assign b1.HTRANS = m_trans;
  assign b0.HWRITE = m_write;  assign b1.HWRITE = m_write;
  assign b0.HSIZE  = m_size;   assign b1.HSIZE  = m_size;
  assign b0.HWDATA = m_wdata;  assign b1.HWDATA = m_wdata;
  assign b0.HREADY = b0.HREADYOUT;
  assign b1.HREADY = b1.HREADYOUT;

  ahb_sram_slave #(.MEM_AW(10), .APERTURE_AW(16), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .bus(b0.slave), .state_o(st0));
  ahb_sram_slave #(.MEM_AW(10), .APERTURE_AW(16), .WAIT_STATES(3)) u1 (
    .HCLK(clk), .HRESET(rst), .bus(b1.slave), .state_o(st1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ap(input int dut, input logic [31:0] a, input logic w, input logic [2:0] sz);
    m_sel0  = (dut == 0);
    m_sel1  = (dut == 1);
    m_trans = 2'b10;
    m_addr  = a;
    m_write = w;
    m_size  = sz;
  endtask

  task automatic idle_ap();
    m_sel0  = 1'b0;
    m_sel1  = 1'b0;
    m_trans = 2'b00;
  endtask

  task automatic wr0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    ap(0, a, 1'b1, sz);
    tick();
    m_wdata = d;
    idle_ap();
    tick();
  endtask

  task automatic rd0(input logic [31:0] a, input logic [31:0] exp, input string tag);
    ap(0, a, 1'b0, 3'd2);
    tick();
    idle_ap();
    chk(tag, b0.HRDATA, exp);
    chk({tag, "_rdy"}, {31'd0, b0.HREADYOUT}, 32'd1);
    tick();
  endtask

  task automatic err0(input logic [31:0] a, input logic [2:0] sz, input string tag);
    ap(0, a, 1'b1, sz);
    tick();
    m_wdata = 32'hFFFF_FFFF;
    idle_ap();
    chk({tag, "_c1_rdy"},  {31'd0, b0.HREADYOUT}, 32'd0);
    chk({tag, "_c1_resp"}, {30'd0, b0.HRESP}, 32'd1);
    tick();
    chk({tag, "_c2_rdy"},  {31'd0, b0.HREADYOUT}, 32'd1);
    chk({tag, "_c2_resp"}, {30'd0, b0.HRESP}, 32'd1);
    tick();
    chk({tag, "_after_resp"}, {30'd0, b0.HRESP}, 32'd0);
  endtask

  // Counts low-ready cycles of the WAIT_STATES=3 instance, bounded.
  task automatic wait_rdy1(output int n);
    n = 0;
    while ((b1.HREADYOUT !== 1'b1) && (n < 16)) begin
      n++;
      tick();
    end
    chk("wait_bound", {31'd0, b1.HREADYOUT}, 32'd1);
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d);
    int n;
    ap(1, a, 1'b1, 3'd2);
    tick();
    m_wdata = d;
    idle_ap();
    wait_rdy1(n);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    m_addr = 32'd0; m_wdata = 32'd0; m_write = 1'b0; m_size = 3'd0;
    idle_ap();
    tick();
    tick();
    chk("rst_rdy",   {31'd0, b0.HREADYOUT}, 32'd1);
    chk("rst_resp",  {30'd0, b0.HRESP}, 32'd0);
    chk("rst_rdata", b0.HRDATA, 32'd0);
    chk("rst_state", {29'd0, st0}, 32'd0);
    rst = 1'b0;
    tick();

    // Word write then separate read, zero wait states.
    ap(0, 32'h10, 1'b1, 3'd2);
    tick();
    m_wdata = 32'hDEAD_BEEF;
    idle_ap();
    chk("w1_rdy",  {31'd0, b0.HREADYOUT}, 32'd1);
    chk("w1_resp", {30'd0, b0.HRESP}, 32'd0);
    tick();
    rd0(32'h10, 32'hDEAD_BEEF, "rd_word");
    chk("rd_word_resp", {30'd0, b0.HRESP}, 32'd0);

    wr0(32'h11, 3'd0, 32'h5A5A_5A5A);
    rd0(32'h10, 32'hDEAD_5AEF, "rd_byte_merge");

    // Pipelined write then read of the same word: forwarding, no stall.
    ap(0, 32'h20, 1'b1, 3'd2);
    tick();
    m_wdata = 32'h1234_5678;
    ap(0, 32'h20, 1'b0, 3'd2);
    chk("fwd_wdata_rdy", {31'd0, b0.HREADYOUT}, 32'd1);
    tick();
    idle_ap();
    chk("fwd_rdata", b0.HRDATA, 32'h1234_5678);
    chk("fwd_rdy",   {31'd0, b0.HREADYOUT}, 32'd1);
    chk("fwd_state", {29'd0, st0}, 32'd2);
    tick();

    wr0(32'h22, 3'd1, 32'hCAFE_CAFE);
    rd0(32'h20, 32'hCAFE_5678, "rd_half_merge");
    wr0(32'h00, 3'd2, 32'h1111_1111);

    // Illegal transfers must answer ERROR twice and leave memory untouched.
    err0(32'h13, 3'd1, "err_misalign");
    rd0(32'h10, 32'hDEAD_5AEF, "err_misalign_mem");
    err0(32'h10, 3'd3, "err_size");
    rd0(32'h10, 32'hDEAD_5AEF, "err_size_mem");
    err0(32'h1000, 3'd2, "err_range");
    rd0(32'h00, 32'h1111_1111, "err_range_mem");

    // Three wait states; a second transfer is held on the bus during the waits.
    wr1(32'h10, 32'hDEAD_BEEF);
    wr1(32'h14, 32'h0102_0304);
    wr1(32'h30, 32'hAAAA_5555);
    ap(1, 32'h10, 1'b0, 3'd2);
    tick();
    ap(1, 32'h14, 1'b0, 3'd2);
    for (int i = 0; i < 3; i++) begin
      chk("ws_low_rdy",   {31'd0, b1.HREADYOUT}, 32'd0);
      chk("ws_low_state", {29'd0, st1}, 32'd1);
      tick();
    end
    chk("ws_data_rdy", {31'd0, b1.HREADYOUT}, 32'd1);
    chk("ws_rdata",    b1.HRDATA, 32'hDEAD_BEEF);
    tick();
    idle_ap();
    chk("ws_second_wait", {31'd0, b1.HREADYOUT}, 32'd0);
    wait_rdy1(n);
    chk("ws_second_cycles", n, 32'd3);
    chk("ws_second_rdata",  b1.HRDATA, 32'h0102_0304);
    tick();

    // Reset in the middle of a waited write drops the write.
    ap(1, 32'h30, 1'b1, 3'd2);
    tick();
    m_wdata = 32'h9999_9999;
    idle_ap();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_rdy",   {31'd0, b1.HREADYOUT}, 32'd1);
    chk("mid_rst_resp",  {30'd0, b1.HRESP}, 32'd0);
    chk("mid_rst_rdata", b1.HRDATA, 32'd0);
    chk("mid_rst_state", {29'd0, st1}, 32'd0);
    rst = 1'b0;
    tick();
    ap(1, 32'h30, 1'b0, 3'd2);
    tick();
    idle_ap();
    wait_rdy1(n);
    chk("mid_rst_mem", b1.HRDATA, 32'hAAAA_5555);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
